// File: rtl/switch_output_arbiter_if.sv
// rtl/switch_output_arbiter_if.sv - handshake bundle between requesting inputs, arbiter and downstream sink
// Signals:
//   req/req_last/req_data  per-input beat request, last flag and data (into the arbiter)
//   grant                  one-hot pop strobe back to the inputs
//   out_valid/out_data     registered output beat
//   out_ready              downstream acceptance
//   owner/busy             current grant holder and LOCK indication
// Modports: master = traffic source/sink side, slave = arbiter side.
interface switch_output_arbiter_if #(
    parameter int INPUT_QTY  = 8,
    parameter int DATA_WIDTH = 64
);
    localparam int OWN_W = (INPUT_QTY > 1) ? $clog2(INPUT_QTY) : 1;

    logic [INPUT_QTY-1:0]                 req;
    logic [INPUT_QTY-1:0]                 req_last;
    logic [INPUT_QTY-1:0][DATA_WIDTH-1:0] req_data;
    logic [INPUT_QTY-1:0]                 grant;
    logic                                 out_valid;
    logic [DATA_WIDTH-1:0]                out_data;
    logic                                 out_ready;
    logic [OWN_W-1:0]                     owner;
    logic                                 busy;

    modport master (
        output req, req_last, req_data, out_ready,
        input  grant, out_valid, out_data, owner, busy
    );

    modport slave (
        input  req, req_last, req_data, out_ready,
        output grant, out_valid, out_data, owner, busy
    );
endinterface

// File: rtl/switch_output_arbiter.sv
// rtl/switch_output_arbiter.sv - packet-aware output arbiter with burst cap and registered output
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset
//   bus    switch_output_arbiter_if.slave (req/req_last/req_data in, grant/out_* /owner/busy out)
// Parameters: INPUT_QTY requesters, DATA_WIDTH beat width, MAX_BURST beats per grant.
// Option: define SWITCH_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module switch_output_arbiter #(
    parameter int INPUT_QTY  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    switch_output_arbiter_if.slave  bus
);
    localparam int OWN_W = (INPUT_QTY > 1) ? $clog2(INPUT_QTY) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? MAX_BURST : 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [OWN_W-1:0] LAST_IDX    = OWN_W'(INPUT_QTY - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                state_q, state_d;
    logic [OWN_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [INPUT_QTY-1:0]  grant_v;
    logic                  beat_granted;
    logic [OWN_W-1:0]      winner;
    logic                  found;
    logic [OWN_W-1:0]      owner_next_idx;

`ifdef SWITCH_ARB_RR_EN
    logic [OWN_W-1:0]      ptr_q, ptr_d;
    int                    rr_sum;

    // First requester at or after the pointer, wrapping past the top index.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_sum = 0;
        for (int k = 0; k < INPUT_QTY; k++) begin
            rr_sum = int'(ptr_q) + k;
            if (rr_sum >= INPUT_QTY) begin
                rr_sum = rr_sum - INPUT_QTY;
            end
            if (!found && bus.req[OWN_W'(rr_sum)]) begin
                winner = OWN_W'(rr_sum);
                found  = 1'b1;
            end
        end
    end
`else
    // Lowest requesting index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < INPUT_QTY; k++) begin
            if (!found && bus.req[OWN_W'(k)]) begin
                winner = OWN_W'(k);
                found  = 1'b1;
            end
        end
    end
`endif

    assign owner_next_idx = (owner_q == LAST_IDX) ? '0 : owner_q + OWN_W'(1);

    // A beat is popped only when the output register is free or draining this cycle.
    always_comb begin
        grant_v = '0;
        if (state_q == LOCK && bus.req[owner_q] && (!out_valid_q || bus.out_ready)) begin
            grant_v[owner_q] = 1'b1;
        end
    end

    assign beat_granted = |grant_v;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef SWITCH_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (beat_granted) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.req_last[owner_q] || (cnt_q + CNT_W'(1)) == BURST_LIMIT) begin
                        state_d = IDLE;
                    end
                end else if (!bus.req[owner_q]) begin
                    // Owner went quiet: give the output up rather than stall others.
                    state_d = IDLE;
                end
`ifdef SWITCH_ARB_RR_EN
                if (state_d == IDLE) begin
                    ptr_d = owner_next_idx;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (beat_granted) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[owner_q];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef SWITCH_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef SWITCH_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

`ifndef SWITCH_ARB_RR_EN
    logic unused_next_idx;
    assign unused_next_idx = ^owner_next_idx;
`endif

    assign bus.grant     = grant_v;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == LOCK);
    assign bus.owner     = (state_q == LOCK) ? owner_q : '0;
endmodule

// File: doc/switch_output_arbiter.md
SWITCH_OUTPUT_ARBITER -- requirements
Module: switch_output_arbiter

Interface
REQ-001 Parameter INPUT_QTY, default 8, number of requesting input ports.
REQ-002 Parameter DATA_WIDTH, default 64, beat width in bits.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant before forced release.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  INPUT_QTY  per-input beat-available request.
REQ-007 req_last  input  INPUT_QTY  per-input flag marking the final beat of a packet.
REQ-008 req_data  input  INPUT_QTY x DATA_WIDTH  per-input beat data.
REQ-009 grant  output  INPUT_QTY  one-hot pop strobe: input i's beat is consumed this cycle.
REQ-010 out_valid  output  1  registered output beat valid.
REQ-011 out_data  output  DATA_WIDTH  registered output beat data.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-013 owner  output  clog2(INPUT_QTY)  index of the current grant holder; 0 when IDLE.
REQ-014 busy  output  1  high while in LOCK.

Function
REQ-015 FSM has two states, IDLE and LOCK.
REQ-016 IDLE: if any req bit is high, select the winner per REQ-024/REQ-025, register it into owner, and enter LOCK next cycle; no grant is asserted in IDLE.
REQ-017 LOCK: grant[owner] = req[owner] AND (NOT out_valid OR out_ready); all other grant bits are 0.
REQ-018 A granted beat loads out_data <= req_data[owner] and sets out_valid next cycle.
REQ-019 Output register clear: when out_valid AND out_ready AND no new grant, out_valid clears next cycle.
REQ-020 Beat counter: increments on each grant, clears on entering LOCK, and is MAX_BURST bits wide or wider.
REQ-021 LOCK -> IDLE when any of the following occurs:
- a granted beat has req_last high;
- a granted beat brings the counter to MAX_BURST;
- req[owner] is low for one LOCK cycle.
REQ-022 Exactly one arbitration bubble cycle (IDLE) separates consecutive grants, including when the same input wins again.
REQ-023 req changes on non-owner inputs during LOCK have no effect.

Configuration
REQ-024 SWITCH_ARB_RR_EN defined: round-robin selection; on every LOCK->IDLE transition, pointer <= (owner+1) mod INPUT_QTY; winner is the first requesting index at or after pointer, with wrap-around.
REQ-025 SWITCH_ARB_RR_EN undefined: fixed priority, lowest requesting index wins; the pointer register is not implemented.

Reset
REQ-026 While reset is high, all of the following are cleared asynchronously: state=IDLE, owner=0, pointer=0, beat counter=0, out_valid=0, out_data=0, busy=0, grant=0.
REQ-027 Reset asserted mid-LOCK abandons the burst without emitting any further beat; the first arbitration after reset deasserts follows REQ-016.

Verification
REQ-028 Single beat: req[2]=1, req_last[2]=1, data 0xDEADBEEFCAFEBABE, out_ready=1 -> busy at cycle 1, grant[2] at cycle 1, out_valid with the data at cycle 2, IDLE at cycle 2.
REQ-029 Priority conflict: req[0], req[1], req[2] all high, single-beat packets 0xAA.., 0xBB.., 0xCC.., with out_ready=1.
- Without the macro: output order is 0xAA.., 0xBB.., 0xCC.., each separated by one bubble cycle.
- With SWITCH_ARB_RR_EN and the pointer preset to 1 by a prior grant to input 0: order is 0xBB.., 0xCC.., 0xAA...
REQ-030 Burst cap: MAX_BURST=4; input 5 presents 6 beats with no req_last -> 4 beats out, IDLE bubble, input 5 re-granted, remaining 2 beats out.
REQ-031 Backpressure: out_ready=0 for 3 cycles during a burst -> out_valid and out_data hold, grant=0, no beat is lost or duplicated.
REQ-032 Reset mid-burst: assert reset after 2 of 4 beats -> outputs zero immediately; after release with no req, out_valid stays 0.
REQ-033 RR fairness: with SWITCH_ARB_RR_EN, all 8 inputs continuously request single-beat packets for 16 grants -> each input is granted exactly twice, in index order 0..7, 0..7.
